// File: rtl/systolic_pe_mac.sv
// Signed integer multiply-accumulate PE for an output-stationary systolic array.
// Optional saturation of the accumulator is enabled by defining PE_SAT_EN; otherwise the sum wraps.
module systolic_pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              acc_clr,
  input  logic              acc_last,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              clr_out,
  output logic              last_out,
  output logic [ACC_W-1:0]  result,
  output logic              res_valid,
  output logic              res_sat
);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic                     clr_p1;
  logic                     last_p1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  base_p1;
  logic signed [ACC_W-1:0]  sum_p1;
  logic                     sat_p1;
  logic                     sticky;
  logic                     sticky_p1;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

`ifdef PE_SAT_EN
  logic signed [ACC_W:0] wide_p1;

  function automatic logic signed [ACC_W:0] add_wide(input logic signed [ACC_W-1:0] base,
                                                     input logic signed [PROD_W-1:0] p);
    return (ACC_W+1)'(base) + (ACC_W+1)'(p);
  endfunction

  function automatic logic overflow(input logic signed [ACC_W:0] w);
    return w[ACC_W] ^ w[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] w);
    if (overflow(w)) begin
      return w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return w[ACC_W-1:0];
  endfunction
`endif

  // Stage 2 arithmetic: a clearing beat starts from zero instead of the running sum
  always_comb begin
    base_p1 = clr_p1 ? '0 : acc;
`ifdef PE_SAT_EN
    wide_p1 = add_wide(base_p1, prod_p1);
    sat_p1  = overflow(wide_p1);
    sum_p1  = saturate(wide_p1);
`else
    sat_p1  = 1'b0;
    sum_p1  = base_p1 + sext_prod(prod_p1);
`endif
    sticky_p1 = (clr_p1 ? 1'b0 : sticky) | sat_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      clr_out   <= 1'b0;
      last_out  <= 1'b0;
      prod_p1   <= '0;
      vld_p1    <= 1'b0;
      clr_p1    <= 1'b0;
      last_p1   <= 1'b0;
      acc       <= '0;
      sticky    <= 1'b0;
      result    <= '0;
      res_valid <= 1'b0;
      res_sat   <= 1'b0;
    end else begin
      // Neighbour forwarding, independent of in_valid
      a_out     <= a_in;
      b_out     <= b_in;
      valid_out <= in_valid;
      clr_out   <= acc_clr;
      last_out  <= acc_last;

      // Stage 1: multiply and qualify sideband with valid
      prod_p1   <= PROD_W'($signed(a_in)) * PROD_W'($signed(b_in));
      vld_p1    <= in_valid;
      clr_p1    <= acc_clr & in_valid;
      last_p1   <= acc_last & in_valid;

      // Stage 2: accumulate and publish on the last beat
      res_valid <= 1'b0;
      if (vld_p1) begin
        acc    <= sum_p1;
        sticky <= sticky_p1;
        if (last_p1) begin
          result    <= sum_p1;
          res_valid <= 1'b1;
          res_sat   <= sticky_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: drives a 32-bit and a 16-bit accumulator PE with the same beats,
// checks both against an arithmetic model every cycle plus hand-computed literals.
module tb_systolic_pe_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, acc_clr, acc_last;
  logic [7:0] a_in, b_in;

  logic [7:0]  a_out_w, b_out_w, a_out_n, b_out_n;
  logic        valid_out_w, clr_out_w, last_out_w, valid_out_n, clr_out_n, last_out_n;
  logic [31:0] result_w;
  logic [15:0] result_n;
  logic        res_valid_w, res_sat_w, res_valid_n, res_sat_n;

  systolic_pe_mac #(.DATA_W(8), .ACC_W(32)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .acc_clr(acc_clr), .acc_last(acc_last), .a_out(a_out_w), .b_out(b_out_w),
    .valid_out(valid_out_w), .clr_out(clr_out_w), .last_out(last_out_w),
    .result(result_w), .res_valid(res_valid_w), .res_sat(res_sat_w));

  systolic_pe_mac #(.DATA_W(8), .ACC_W(16)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .acc_clr(acc_clr), .acc_last(acc_last), .a_out(a_out_n), .b_out(b_out_n),
    .valid_out(valid_out_n), .clr_out(clr_out_n), .last_out(last_out_n),
    .result(result_n), .res_valid(res_valid_n), .res_sat(res_sat_n));

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model state, index 0 = 32-bit accumulator, index 1 = 16-bit accumulator
  bit     started = 1'b0;
  longint macc[2], exp_res[2], pend_res[2];
  bit     msticky[2], exp_rv[2], exp_sat[2], pend_v[2], pend_sat[2];
  logic [7:0] ea, eb;
  bit     ev, ec, el;
  longint full, val, lim;
  bit     s;

  function automatic int width(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Beats are folded into the model at the edge that captures them; results surface one edge later
  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      for (int k = 0; k < 2; k++) begin
        macc[k] = 0; msticky[k] = 0; exp_res[k] = 0; exp_rv[k] = 0;
        exp_sat[k] = 0; pend_v[k] = 0; pend_res[k] = 0; pend_sat[k] = 0;
      end
      ea = 8'd0; eb = 8'd0; ev = 0; ec = 0; el = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_rv[k] = pend_v[k];
        if (pend_v[k]) begin
          exp_res[k] = pend_res[k];
          exp_sat[k] = pend_sat[k];
        end
        pend_v[k] = 0;
        if (in_valid) begin
          full = (acc_clr ? 64'sd0 : macc[k]) +
                 longint'($signed(a_in)) * longint'($signed(b_in));
          if (acc_clr) msticky[k] = 0;
`ifdef PE_SAT_EN
          lim = longint'(1) << (width(k) - 1);
          if (full > lim - 1) begin val = lim - 1; s = 1; end
          else if (full < -lim) begin val = -lim; s = 1; end
          else begin val = full; s = 0; end
`else
          lim = 0;
          val = wrap(full, width(k));
          s = 0;
`endif
          macc[k] = val;
          msticky[k] = msticky[k] | s;
          if (acc_last) begin
            pend_v[k] = 1; pend_res[k] = val; pend_sat[k] = msticky[k];
          end
        end
      end
      ea = a_in; eb = b_in; ev = in_valid; ec = acc_clr; el = acc_last;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("res_valid_w", longint'(res_valid_w), longint'(exp_rv[0]));
      chk("result_w", longint'($signed(result_w)), exp_res[0]);
      chk("res_sat_w", longint'(res_sat_w), longint'(exp_sat[0]));
      chk("res_valid_n", longint'(res_valid_n), longint'(exp_rv[1]));
      chk("result_n", longint'($signed(result_n)), exp_res[1]);
      chk("res_sat_n", longint'(res_sat_n), longint'(exp_sat[1]));
      chk("pass_a", longint'({a_out_w, a_out_n}), longint'({ea, ea}));
      chk("pass_b", longint'({b_out_w, b_out_n}), longint'({eb, eb}));
      chk("pass_ctl", longint'({valid_out_w, clr_out_w, last_out_w, valid_out_n, clr_out_n, last_out_n}),
          longint'({ev, ec, el, ev, ec, el}));
    end
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic l);
    in_valid = v; a_in = a; b_in = b; acc_clr = c; acc_last = l;
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; acc_clr = 1'b0; acc_last = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      @(posedge clk); #1;
    end
  endtask

  // Waits (bounded) for the result pulse after the last beat and checks literal values
  task automatic wait_res(input string name, input longint exp_w, input longint exp_n,
                          input longint exp_sat_n);
    int lat;
    lat = 0;
    set_idle();
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (res_valid_w) lat = i;
    end
    chk({name, "_latency"}, longint'(lat), 64'sd2);
    chk({name, "_lit_w"}, longint'($signed(result_w)), exp_w);
    chk({name, "_lit_n"}, longint'($signed(result_n)), exp_n);
    chk({name, "_lit_sat_n"}, longint'(res_sat_n), exp_sat_n);
    @(negedge clk);
    chk({name, "_pulse_len"}, longint'(res_valid_w | res_valid_n), 64'sd0);
  endtask

  int pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    in_valid = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
    acc_clr = 1'($urandom); acc_last = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b1; acc_clr = 1'b1; acc_last = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
    @(posedge clk); #1;
    chk("rst_result", longint'(result_w), 64'sd0);
    chk("rst_flags", longint'({res_valid_w, res_sat_w, valid_out_w, a_out_w}), 64'sd0);
    rst = 1'b0;
    idle(2);

    // Contiguous dot product {2,4,8,16}^2
    drive(1'b1, 8'd2, 8'd2, 1'b1, 1'b0);
    drive(1'b1, 8'd4, 8'd4, 1'b0, 1'b0);
    drive(1'b1, 8'd8, 8'd8, 1'b0, 1'b0);
    drive(1'b1, 8'd16, 8'd16, 1'b0, 1'b1);
    wait_res("dot340", 64'sd340, 64'sd340, 64'sd0);

    // Single-beat vectors
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
    wait_res("neg128sq", 64'sd16384, 64'sd16384, 64'sd0);
    drive(1'b1, 8'hFD, 8'd5, 1'b1, 1'b1);
    wait_res("m3x5", -64'sd15, -64'sd15, 64'sd0);
    chk("m3x5_hex", longint'(result_w), 64'h0000_0000_FFFF_FFF1);

    // Same vector with bubbles of 1..3 cycles
    drive(1'b1, 8'd2, 8'd2, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 8'd4, 8'd4, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 8'd8, 8'd8, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 8'd16, 8'd16, 1'b0, 1'b1);
    wait_res("dot340_gaps", 64'sd340, 64'sd340, 64'sd0);

    // Back-to-back vectors
    drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0);
    drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b1);
    drive(1'b1, 8'd3, 8'd3, 1'b1, 1'b1);
    set_idle();
    chk("b2b_first_vld", longint'(res_valid_w), 64'sd1);
    chk("b2b_first_res", longint'($signed(result_w)), 64'sd5);
    @(posedge clk); #1;
    chk("b2b_second_vld", longint'(res_valid_w), 64'sd1);
    chk("b2b_second_res", longint'($signed(result_w)), 64'sd9);
    idle(2);

    // Overflow of the 16-bit accumulator: 3 * 127*127 = 48387
    drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0);
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b1);
`ifdef PE_SAT_EN
    wait_res("ovf16", 64'sd48387, 64'sd32767, 64'sd1);
`else
    wait_res("ovf16", 64'sd48387, -64'sd17149, 64'sd0);
`endif

    // Reset on the last beat of a vector: nothing is published
    drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0);
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b1);
    rst = 1'b0;
    pulses = 0;
    set_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid_w || res_valid_n) pulses++;
    end
    chk("midrst_pulses", longint'(pulses), 64'sd0);
    chk("midrst_result", longint'({result_w, result_n, res_sat_n}), 64'sd0);

    // After reset, a beat without clear accumulates onto zero
    @(posedge clk); #1;
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1);
    wait_res("postrst", 64'sd9, 64'sd9, 64'sd0);

    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
